// File: rtl/refresh_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : refresh_scheduler                                             |
// | Purpose  : Periodic all-bank refresh requester with postponement credit, |
// |            debt-driven priority and tRFC busy window.                    |
// | Option   : REFRESH_PULL_IN_EN enables opportunistic pulled-in refreshes. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module refresh_scheduler #(
  parameter int PEND_MAX = 8,
  parameter int PRIO_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cfg_trefi,
  input  logic [9:0]        cfg_trfc,
  input  logic [3:0]        cfg_urgent_thr,
  input  logic              ref_en,
  input  logic              bus_idle,
  input  logic              ref_ack,
  output logic              ref_req,
  output logic [PRIO_W-1:0] ref_prio,
  output logic              ref_busy,
  output logic [3:0]        ref_pending,
  output logic              ref_overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RFC  = 2'd2
  } state_t;

  localparam logic [3:0]        C_PEND_MAX = 4'(PEND_MAX);
  localparam logic [PRIO_W-1:0] C_PRIO_MAX = '1;
  localparam logic [PRIO_W-1:0] C_PRIO_ONE = PRIO_W'(1);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [3:0]        pend_q, pend_d;
  logic [9:0]        rfc_q, rfc_d;
  logic [PRIO_W-1:0] prio_q, prio_d;
  logic              ovf_q, ovf_d;

  logic tick;
  logic grant;
  logic norm_grant;
  logic tick_inc;
  logic pull_start;
  logic pull_q, pull_d;

  assign tick  = (cfg_trefi != 16'd0) && (cnt_q == cfg_trefi - 16'd1);
  assign grant = (state_q == S_REQ) && ref_ack;

`ifdef REFRESH_PULL_IN_EN
  logic [1:0] pulled_q, pulled_d;
  logic       pull_grant;

  assign pull_grant = grant && pull_q;
  assign norm_grant = grant && !pull_q;
  // A tick that finds pulled-in credit repays it instead of adding debt.
  assign tick_inc   = tick && (pulled_q == 2'd0);
  assign pull_start = ref_en && bus_idle && (pend_d == 4'd0) &&
                      (cfg_trefi != 16'd0) && (cnt_q >= {1'b0, cfg_trefi[15:1]}) &&
                      (pulled_q != 2'd2);

  always_comb begin
    pulled_d = pulled_q;
    if (pull_grant && !(tick && (pulled_q != 2'd0))) begin
      pulled_d = pulled_q + 2'd1;
    end else if (!pull_grant && tick && (pulled_q != 2'd0)) begin
      pulled_d = pulled_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulled_q <= 2'd0;
    end else begin
      pulled_q <= pulled_d;
    end
  end
`else
  logic unused_bus_idle;

  assign unused_bus_idle = bus_idle;
  assign norm_grant      = grant;
  assign tick_inc        = tick;
  assign pull_start      = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (cfg_trefi == 16'd0 || tick) begin
      cnt_d = 16'd0;
    end
  end

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (tick_inc && !norm_grant) begin
      if (pend_q == C_PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (!tick_inc && norm_grant) begin
      pend_d = pend_q - 4'd1;
    end
  end

  // Looking at pend_d lets a tick raise ref_req on the very next cycle.
  always_comb begin
    state_d = state_q;
    rfc_d   = rfc_q;
    pull_d  = pull_q;
    case (state_q)
      S_IDLE: begin
        pull_d = 1'b0;
        if (ref_en && (pend_d != 4'd0)) begin
          state_d = S_REQ;
        end else if (pull_start) begin
          state_d = S_REQ;
          pull_d  = 1'b1;
        end
      end
      S_REQ: begin
        if (ref_ack) begin
          state_d = S_RFC;
          rfc_d   = (cfg_trfc == 10'd0) ? 10'd1 : cfg_trfc;
        end
      end
      S_RFC: begin
        if (rfc_q <= 10'd1) begin
          state_d = S_IDLE;
        end else begin
          rfc_d = rfc_q - 10'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    prio_d = '0;
    if (pull_d && (state_d == S_REQ)) begin
      prio_d = '0;
    end else if (pend_d == C_PEND_MAX) begin
      prio_d = C_PRIO_MAX;
    end else if (pend_d >= cfg_urgent_thr) begin
      prio_d = C_PRIO_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      pend_q  <= 4'd0;
      rfc_q   <= 10'd0;
      prio_q  <= '0;
      ovf_q   <= 1'b0;
      pull_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rfc_q   <= rfc_d;
      prio_q  <= prio_d;
      ovf_q   <= ovf_d;
      pull_q  <= pull_d;
    end
  end

  assign ref_req      = (state_q == S_REQ);
  assign ref_busy     = (state_q == S_RFC);
  assign ref_prio     = prio_q;
  assign ref_pending  = pend_q;
  assign ref_overflow = ovf_q;

endmodule
`default_nettype wire

// File: doc/refresh_scheduler.md
Name: refresh_scheduler

Overview:
- Generates periodic all-bank refresh requests into the bank arbiter's refresh-handler slot.
- Tracks postponed refreshes as a credit counter and raises request priority as debt grows, so the arbiter can defer refresh behind bank-engine/AiM traffic without violating the postponement limit.
- Enforces tRFC after each granted refresh.

Parameters:
PEND_MAX, 8, max postponed refreshes held (credit counter saturation value, 1..15)
PRIO_W, 2, width of ref_prio

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cfg_trefi  input  16  refresh interval in clk cycles; 0 disables interval ticks
cfg_trfc  input  10  refresh busy time in clk cycles; 0 treated as 1
cfg_urgent_thr  input  4  pending count at/above which priority is raised
ref_en  input  1  allows new requests to be raised
bus_idle  input  1  arbiter has no other active requester (used only with optional feature)
ref_ack  input  1  arbiter grant; valid only while ref_req=1
ref_req  output  1  refresh request to arbiter
ref_prio  output  PRIO_W  request priority
ref_busy  output  1  high during tRFC window
ref_pending  output  4  current postponed-refresh count
ref_overflow  output  1  sticky: tick arrived with pending==PEND_MAX

Behaviour:
- Reset: ref_req=0, ref_prio=0, ref_busy=0, ref_pending=0, ref_overflow=0, interval counter=0, state IDLE. Reset mid-REQ/RFC aborts immediately; outstanding debt is discarded.
- Interval counter: up-counter; when cnt==cfg_trefi-1, a tick is generated and cnt<=0, else cnt++. First tick occurs cfg_trefi cycles after reset release. cfg_trefi==0: cnt held at 0, no ticks. A cfg_trefi change below the current cnt causes wrap via 16-bit overflow (no special handling); software changes it only while ref_en=0.
- Ticks run regardless of ref_en and state.
- Pending update per cycle: +1 on tick, -1 on accepted grant (ref_req&&ref_ack). Both in the same cycle: net unchanged. A tick at PEND_MAX without a same-cycle grant: pending stays PEND_MAX and ref_overflow<=1 (cleared only by rst).
- FSM:
  IDLE: if ref_en && pending>0 -> REQ (ref_req rises next cycle). Minimum tick-to-req latency is 1 cycle.
  REQ: ref_req=1, held until ref_ack; never withdrawn, even if ref_en falls. On ref_ack -> RFC, rfc counter loaded with max(cfg_trfc,1).
  RFC: ref_req=0, ref_busy=1 for exactly max(cfg_trfc,1) cycles, then IDLE. ref_ack is ignored outside REQ.
- Priority (registered, tracks pending in every state): 0 if pending<cfg_urgent_thr; 1 if pending>=cfg_urgent_thr; 3 (all ones) if pending==PEND_MAX. cfg_urgent_thr==0 means priority is always >=1. Priority may rise while ref_req is held and falls only after a grant.
- ref_pending is a registered copy of the credit counter.
- Back-to-back: with pending>=2 and ref_en=1, the next ref_req rises 1 cycle after RFC exits.

Optional Feature:
REFRESH_PULL_IN_EN
- Defined: in IDLE with ref_en=1, pending==0, bus_idle=1 and cnt>=cfg_trefi/2, a pulled-in refresh is requested at priority 0. On its grant, pulled-credit (0..2) increments and pending is not decremented. A subsequent tick with pulled-credit>0 decrements pulled-credit instead of incrementing pending. Pull-in is suppressed when pulled-credit==2.
- Undefined: bus_idle is ignored and no pulled-credit register exists. The port is retained.

Test Plan:
- cfg_trefi=100, cfg_trfc=10, ref_en=1, ack 1 cycle after req: first ref_req at cycle 101; ref_busy high for exactly 10 cycles; ref_pending returns to 0.
- cfg_trefi=10, ack withheld, PEND_MAX=8, thr=4: pending 1..8; ref_prio goes 0→1 at pending=4 and 3 at pending=8; the 9th tick sets ref_overflow with pending=8.
- Continuing from the previous case, ack every request: 8 back-to-back refreshes, each separated by tRFC+1 cycles; ref_prio returns to 0; ref_overflow stays 1.
- Tick and ack in the same cycle with pending=1: pending stays 1 and the FSM enters RFC.
- Assert rst during RFC with pending=3: all outputs are 0 immediately; the first tick occurs cfg_trefi cycles after release.
- (REFRESH_PULL_IN_EN) cfg_trefi=100, bus_idle=1: pull-in req at cnt=50 with prio 0; after grant, the tick at cycle 100 leaves pending=0 and pulled-credit=0.
